iq_symbol_sched: RTL and testbench

IQ_SYMBOL_SCHED -- requirements
Module: iq_symbol_sched

---
 rtl/iq_symbol_sched.sv | 175 +++++++++++++++++
 tb/tb_iq_symbol_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/iq_symbol_sched.sv
// I/Q symbol scheduler: buffers upstream symbols and holds each one for sym_div+1 clocks.
// Optional preamble generator is compiled in with `define IQSCHED_PREAMBLE_EN.
module iq_symbol_sched #(
    parameter int IQ_W       = 4,
    parameter int FIFO_DEPTH = 4
`ifdef IQSCHED_PREAMBLE_EN
    ,
    parameter int PRE_LEN    = 8
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             sym_div,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [IQ_W-1:0] s_i,
    input  logic signed [IQ_W-1:0] s_q,
    input  logic                   s_last,
    output logic signed [IQ_W-1:0] i_out,
    output logic signed [IQ_W-1:0] q_out,
    output logic                   sym_strobe,
    output logic                   busy,
    output logic                   underrun,
    output logic [1:0]             fsm_state
);

    // Handshake: a symbol transfers on any rising edge where s_valid && s_ready;
    // s_ready depends only on the registered FIFO count, never on a same-cycle pop.

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 * IQ_W + 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE     = 2'd0;
`ifdef IQSCHED_PREAMBLE_EN
    localparam logic [1:0] S_PREAMBLE = 2'd1;
    localparam int         PW         = $clog2(PRE_LEN + 1);
    localparam logic signed [IQ_W-1:0] I_MAX = {1'b0, {(IQ_W - 1) {1'b1}}};
`endif
    localparam logic [1:0] S_DATA     = 2'd2;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, push, pop;

    logic [1:0]    state;
    logic [7:0]    cnt, div_l;
    logic          last_cur;
    logic          boundary;
    logic          data_slot;
`ifdef IQSCHED_PREAMBLE_EN
    logic [PW-1:0] pre_idx;
    logic          pre_done;
    assign pre_done = (pre_idx == PW'(PRE_LEN - 1));
`endif

    assign empty     = (count == '0);
    assign s_ready   = (count != FULL_CNT);
    assign push      = s_valid && s_ready;
    assign boundary  = (cnt == div_l);
    assign pop       = data_slot && !empty;
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    // data_slot marks a cycle where the next data symbol (or an underrun gap) is loaded.
    always_comb begin
        data_slot = 1'b0;
        case (state)
`ifdef IQSCHED_PREAMBLE_EN
            S_PREAMBLE: data_slot = boundary && pre_done;
`else
            S_IDLE:     data_slot = !empty;
`endif
            S_DATA:     data_slot = boundary && !last_cur;
            default:    data_slot = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_i, s_q, s_last};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            div_l      <= '0;
            last_cur   <= 1'b0;
            i_out      <= '0;
            q_out      <= '0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
`ifdef IQSCHED_PREAMBLE_EN
            pre_idx    <= '0;
`endif
        end else begin
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        div_l <= sym_div;
                        cnt   <= '0;
`ifdef IQSCHED_PREAMBLE_EN
                        state      <= S_PREAMBLE;
                        pre_idx    <= '0;
                        i_out      <= I_MAX;
                        q_out      <= '0;
                        sym_strobe <= 1'b1;
`endif
                    end
                end
`ifdef IQSCHED_PREAMBLE_EN
                S_PREAMBLE: begin
                    if (!boundary) begin
                        cnt <= cnt + 8'd1;
                    end else if (!pre_done) begin
                        cnt        <= '0;
                        pre_idx    <= pre_idx + 1'b1;
                        i_out      <= -i_out;
                        sym_strobe <= 1'b1;
                    end
                end
`endif
                S_DATA: begin
                    if (!boundary) begin
                        cnt <= cnt + 8'd1;
                    end else if (last_cur) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        last_cur <= 1'b0;
                        i_out    <= '0;
                        q_out    <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Loading a slot: real data when available, otherwise a zero symbol flagged as underrun.
            if (data_slot) begin
                state      <= S_DATA;
                cnt        <= '0;
                sym_strobe <= 1'b1;
                if (!empty) begin
                    i_out    <= mem[rd_ptr][EW-1 -: IQ_W];
                    q_out    <= mem[rd_ptr][IQ_W:1];
                    last_cur <= mem[rd_ptr][0];
                end else begin
                    i_out    <= '0;
                    q_out    <= '0;
                    last_cur <= 1'b0;
                    underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_symbol_sched.sv
// Directed bench for iq_symbol_sched; preamble scenario runs when IQSCHED_PREAMBLE_EN is defined.
module tb_iq_symbol_sched;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        sym_div;
    logic              s_valid;
    logic              s_ready;
    logic signed [3:0] s_i, s_q;
    logic              s_last;
    logic signed [3:0] i_out, q_out;
    logic              sym_strobe, busy, underrun;
    logic [1:0]        fsm_state;

    int checks = 0;
    int errors = 0;
    int accepts;
    logic found;

    iq_symbol_sched dut (
        .clk(clk), .rst(rst), .sym_div(sym_div),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_i(s_i), .s_q(s_q), .s_last(s_last),
        .i_out(i_out), .q_out(q_out),
        .sym_strobe(sym_strobe), .busy(busy), .underrun(underrun),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Waits for the next falling edge, then checks the registered outputs.
    task automatic cyc(input string tag, input int ei, input int eq,
                       input logic es, input logic eb, input logic eu);
        @(negedge clk);
        chk({tag, ".i"}, i_out, ei);
        chk({tag, ".q"}, q_out, eq);
        chk({tag, ".strobe"}, sym_strobe, es);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".underrun"}, underrun, eu);
    endtask

    task automatic hold(input string tag, input int ei, input int eq, input int n);
        cyc(tag, ei, eq, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < n; k++) cyc(tag, ei, eq, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_sym(input int i, input int q, input logic last);
        s_i    = 4'(i);
        s_q    = 4'(q);
        s_last = last;
    endtask

    task automatic do_reset(input string tag);
        rst     = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".ready"}, s_ready, 1);
        chk({tag, ".i"}, i_out, 0);
        chk({tag, ".q"}, q_out, 0);
        chk({tag, ".strobe"}, sym_strobe, 0);
        chk({tag, ".underrun"}, underrun, 0);
        chk({tag, ".state"}, fsm_state, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sym_div = 8'd0; s_valid = 1'b0;
        set_sym(0, 0, 1'b0);

        // Three-symbol burst, sym_div=3; sym_div change mid-burst must be ignored.
        do_reset("rst0");
        sym_div = 8'd3; s_valid = 1'b1; set_sym(1, 2, 1'b0);
        cyc("b3.idle", 0, 0, 1'b0, 1'b0, 1'b0);
        set_sym(3, -4, 1'b0);
        cyc("b3.s1", 1, 2, 1'b1, 1'b1, 1'b0);
        set_sym(-1, 7, 1'b1);
        cyc("b3.s1", 1, 2, 1'b0, 1'b1, 1'b0);
        s_valid = 1'b0; s_last = 1'b0; sym_div = 8'd0;
        cyc("b3.s1", 1, 2, 1'b0, 1'b1, 1'b0);
        cyc("b3.s1", 1, 2, 1'b0, 1'b1, 1'b0);
        hold("b3.s2", 3, -4, 4);
        hold("b3.s3", -1, 7, 4);
        cyc("b3.end", 0, 0, 1'b0, 1'b0, 1'b0);
        cyc("b3.end2", 0, 0, 1'b0, 1'b0, 1'b0);

        // Back-pressure: stalled schedule, s_valid held.
        do_reset("rst1");
        sym_div = 8'd255; s_valid = 1'b1; set_sym(1, 1, 1'b0);
        accepts = 0;
        for (int k = 0; k < 20; k++) begin
            if (s_ready) accepts++;
            @(negedge clk);
        end
        chk("bp.accepts", accepts, 5);
        chk("bp.ready_low", s_ready, 0);
        chk("bp.busy", busy, 1);
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            if (s_ready) accepts++;
            @(negedge clk);
            if (sym_strobe) found = 1'b1;
        end
        chk("bp.pop_seen", found, 1);
        chk("bp.no_extra_accept", accepts, 5);
        chk("bp.ready_after_pop", s_ready, 1);
        chk("bp.next_i", i_out, 1);
        s_valid = 1'b0;

        // Starvation: underrun gap, then the burst resumes.
        do_reset("rst2");
        sym_div = 8'd1; s_valid = 1'b1; set_sym(4, -2, 1'b0);
        cyc("ur.idle", 0, 0, 1'b0, 1'b0, 1'b0);
        s_valid = 1'b0;
        hold("ur.a", 4, -2, 2);
        cyc("ur.gap", 0, 0, 1'b1, 1'b1, 1'b1);
        s_valid = 1'b1; set_sym(-3, 5, 1'b1);
        cyc("ur.gap2", 0, 0, 1'b0, 1'b1, 1'b0);
        s_valid = 1'b0;
        hold("ur.b", -3, 5, 2);
        cyc("ur.end", 0, 0, 1'b0, 1'b0, 1'b0);

        // Reset mid-burst with two symbols queued, then a fresh burst.
        do_reset("rst3");
        sym_div = 8'd3; s_valid = 1'b1; set_sym(1, 1, 1'b0);
        cyc("mr.idle", 0, 0, 1'b0, 1'b0, 1'b0);
        set_sym(2, 2, 1'b0);
        cyc("mr.s1", 1, 1, 1'b1, 1'b1, 1'b0);
        set_sym(3, 3, 1'b1);
        cyc("mr.s1", 1, 1, 1'b0, 1'b1, 1'b0);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mr.busy", busy, 0);
        chk("mr.i", i_out, 0);
        chk("mr.q", q_out, 0);
        chk("mr.ready", s_ready, 1);
        chk("mr.strobe", sym_strobe, 0);
        rst = 1'b0;
        s_valid = 1'b1; set_sym(2, -3, 1'b1);
        cyc("mr.idle2", 0, 0, 1'b0, 1'b0, 1'b0);
        s_valid = 1'b0;
        hold("mr.fresh", 2, -3, 4);
        cyc("mr.end", 0, 0, 1'b0, 1'b0, 1'b0);
        cyc("mr.end2", 0, 0, 1'b0, 1'b0, 1'b0);

        // sym_div=0: a new symbol every cycle.
        do_reset("rst4");
        sym_div = 8'd0; s_valid = 1'b1; set_sym(1, 1, 1'b0);
        cyc("d0.idle", 0, 0, 1'b0, 1'b0, 1'b0);
        set_sym(2, 2, 1'b0);
        cyc("d0.s1", 1, 1, 1'b1, 1'b1, 1'b0);
        set_sym(3, 3, 1'b0);
        cyc("d0.s2", 2, 2, 1'b1, 1'b1, 1'b0);
        set_sym(4, 4, 1'b1);
        cyc("d0.s3", 3, 3, 1'b1, 1'b1, 1'b0);
        s_valid = 1'b0;
        cyc("d0.s4", 4, 4, 1'b1, 1'b1, 1'b0);
        cyc("d0.end", 0, 0, 1'b0, 1'b0, 1'b0);

`ifdef IQSCHED_PREAMBLE_EN
        // Preamble: 8 alternating +7/-7 symbols of 2 cycles, then the data symbol.
        do_reset("rst5");
        sym_div = 8'd1; s_valid = 1'b1; set_sym(5, 5, 1'b1);
        cyc("pre.idle", 0, 0, 1'b0, 1'b0, 1'b0);
        s_valid = 1'b0;
        for (int k = 0; k < 8; k++) hold("pre.sym", (k % 2 == 0) ? 7 : -7, 0, 2);
        hold("pre.data", 5, 5, 2);
        cyc("pre.end", 0, 0, 1'b0, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
